instr_loader_mem: RTL

Program memory and boot loader for the IL2234 processor. Sits directly upstream of the control FSM: accepts a program as a stream of instruction words over a valid/ready load port, stores it in a 2^P-word memory, then serves the FSM's fetch reads with one-cycle latency. A `core_run` output keeps the core held until a complete program has been loaded.

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_sp_ram.sv | 22 ++
 rtl/instr_loader_mem.sv | 84 ++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types for the IL2234 program memory / boot loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Instruction word width: 4-bit opcode plus two register fields.
  function automatic int unsigned instr_width(input int unsigned m);
    return 4 + 2 * m;
  endfunction

endpackage

// File: rtl/instr_sp_ram.sv
// Instruction storage: one synchronous write port, one enabled synchronous read port.
module instr_sp_ram #(
  parameter int unsigned P = 6,
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         we,
  input  logic [P-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [P-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**P];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_loader_mem.sv
// Program memory with valid/ready boot loader; holds the core until a full program is loaded.
module instr_loader_mem
  import instr_loader_pkg::*;
#(
  parameter int unsigned M = 4,
  parameter int unsigned P = 6,
  parameter int unsigned W = instr_width(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prog_start,
  input  logic         prog_valid,
  output logic         prog_ready,
  input  logic [W-1:0] prog_data,
  input  logic         prog_last,
  output logic         load_error,
  output logic         core_run,
  input  logic         en_read_instr,
  input  logic [P-1:0] raddr_instr,
  output logic [W-1:0] instr_in
);

  state_t       state;
  logic [P:0]   wptr;
  logic         accept;
  logic         mem_we;
  logic         mem_re;
  logic         fetch_live;
  logic [W-1:0] rdata;

  // A start pulse takes priority over any word presented in the same cycle.
  assign accept = prog_valid & prog_ready & ~prog_start;
  assign mem_we = accept & ~wptr[P];
  assign mem_re = (state == RUN) & en_read_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wptr       <= '0;
      prog_ready <= 1'b0;
      load_error <= 1'b0;
      core_run   <= 1'b0;
    end else begin
      core_run <= (state == RUN) & ~load_error;
      if (prog_start) begin
        state      <= LOAD;
        wptr       <= '0;
        load_error <= 1'b0;
        prog_ready <= 1'b1;
      end else if (state == LOAD && accept) begin
        if (wptr[P]) load_error <= 1'b1;
        else         wptr       <= wptr + 1'b1;
        if (prog_last) begin
          state      <= RUN;
          prog_ready <= 1'b0;
        end
      end
    end
  end

  // The RAM read register has no reset, so the output is forced to zero
  // until a fetch has been issued in the current RUN period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fetch_live <= 1'b0;
    else if (state != RUN)   fetch_live <= 1'b0;
    else if (en_read_instr)  fetch_live <= 1'b1;
  end

  assign instr_in = fetch_live ? rdata : '0;

  instr_sp_ram #(
    .P (P),
    .W (W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr[P-1:0]),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (raddr_instr),
    .rdata (rdata)
  );

endmodule
